imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM word-write bundle for imem_loader.
// master = stream source / RAM side, slave = the loader itself.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Frame loader: SYNC, 16-bit word count, LE data words -> one RAM write per word (1 clk after 4th byte,
// 4 bytes / 5 clks max, rx_ready low during the write cycle). LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHK
    } state_t;

    state_t      state_q;
    logic        rx_ready_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        hold_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] len_q;
    logic [15:0] word_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] word_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_q;
`endif

    logic        hs;
    logic [15:0] len_d;
    logic [15:0] word_cnt_d;

    assign hs         = bus.rx_valid & rx_ready_q;
    assign len_d      = {bus.rx_data, len_q[7:0]};
    assign word_cnt_d = word_cnt_q + 16'd1;

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_done  = done_q;
    assign bus.load_err   = err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (hs && bus.rx_data == SYNC_BYTE) begin
                        hold_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (hs) begin
                        len_q[7:0] <= bus.rx_data;
                        state_q    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (hs) begin
                        len_q[15:8] <= bus.rx_data;
                        word_cnt_q  <= '0;
                        byte_cnt_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        chk_q       <= '0;
`endif
                        if (len_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= S_CHK;
`else
                            hold_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
`endif
                        end else if (32'(len_d) > 32'(DEPTH_WORDS)) begin
                            // cpu_hold stays set: a rejected image must not run.
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        word_q     <= {bus.rx_data, word_q[23:8]};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_q      <= chk_q ^ bus.rx_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            rx_ready_q <= 1'b0;
                            we_q       <= 1'b1;
                            addr_q     <= BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                            wdata_q    <= {bus.rx_data, word_q};
                            state_q    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    rx_ready_q <= 1'b1;
                    word_cnt_q <= word_cnt_d;
                    if (word_cnt_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= S_CHK;
`else
                        hold_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
`endif
                    end else begin
                        state_q <= S_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (hs) begin
                        state_q <= S_IDLE;
                        if (bus.rx_data == chk_q) begin
                            hold_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued as frames are sent and
// popped by a write monitor. Define LOADER_CHECKSUM_EN to also exercise the checksum byte.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] exp_q[$];
    int          we_times[$];
    logic [31:0] img[$];
    logic [7:0]  last_xor;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every imem_we pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            logic [63:0] e;
            we_times.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%h data=%h (no write expected)",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.imem_addr, bus.imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL imem_write got addr=%h data=%h expected addr=%h data=%h",
                             bus.imem_addr, bus.imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the byte's handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.rx_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_handshake_timeout byte=%h rx_ready=%b expected 1", b, bus.rx_ready);
        end else begin
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    // Sends SYNC, N and the words in img; stop_bytes >= 0 truncates the data after that many bytes.
    task automatic send_frame(input logic [15:0] n, input int maxgap, input int stop_bytes);
        logic [31:0] wd;
        logic [7:0]  b;
        last_xor = 8'h00;
        for (int w = 0; w < img.size(); w++)
            if (stop_bytes < 0 || (w + 1) * 4 <= stop_bytes)
                exp_q.push_back({BASE + 32'(w) * 32'd4, img[w]});
        send_byte(8'hA5, 0);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
        for (int i = 0; i < img.size() * 4; i++) begin
            if (stop_bytes >= 0 && i >= stop_bytes) break;
            wd = img[i / 4];
            b  = wd[(i % 4) * 8 +: 8];
            last_xor = last_xor ^ b;
            send_byte(b, int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic finish_frame();
`ifdef LOADER_CHECKSUM_EN
        send_byte(last_xor, 0);
`endif
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.rx_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_ready got %b expected 0", bus.rx_ready); end
        n_checks++; if (bus.imem_we !== 1'b0)   begin n_fail++; $display("FAIL reset_imem_we got %b expected 0", bus.imem_we); end
        n_checks++; if (bus.imem_addr !== BASE) begin n_fail++; $display("FAIL reset_imem_addr got %h expected %h", bus.imem_addr, BASE); end
        n_checks++; if (bus.imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_imem_wdata got %h expected 0", bus.imem_wdata); end
        n_checks++; if (bus.cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL reset_cpu_hold got %b expected 0", bus.cpu_hold); end
        n_checks++; if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done got %b expected 0", bus.load_done); end
        n_checks++; if (bus.load_err !== 1'b0)  begin n_fail++; $display("FAIL reset_load_err got %b expected 0", bus.load_err); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.rx_ready !== 1'b1)  begin n_fail++; $display("FAIL idle_rx_ready got %b expected 1", bus.rx_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] s [11];
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h11, 8'h00};
        exp_q.push_back({BASE + 32'h0, 32'h0000_0013});
        exp_q.push_back({BASE + 32'h4, 32'h0011_00B3});
        last_xor = 8'h00;
        for (int i = 0; i < 11; i++) begin
            if (i >= 3) last_xor = last_xor ^ s[i];
            send_byte(s[i], 0);
            n_checks++;
            if (bus.cpu_hold !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_hold_during_frame byte=%0d got %b expected 1", i, bus.cpu_hold);
            end
        end
        finish_frame();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL basic_hold_end got %b expected 0", bus.cpu_hold); end
        n_checks++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b expected 1", bus.load_done); end
        n_checks++; if (exp_q.size() != 0)      begin n_fail++; $display("FAIL basic_writes_missing got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_sync_skip();
        int nw;
        nw = we_times.size();
        img.delete();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_frame(16'd0, 0, -1);
        finish_frame();
        repeat (2) @(negedge clk);
        n_checks++; if (we_times.size() != nw)  begin n_fail++; $display("FAIL skip_no_write got %0d writes expected 0", we_times.size() - nw); end
        n_checks++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL skip_done got %b expected 1", bus.load_done); end
        n_checks++; if (bus.cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL skip_hold got %b expected 0", bus.cpu_hold); end
    endtask

    task automatic test_len_err();
        int nw;
        nw = we_times.size();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        repeat (3) @(negedge clk);
        n_checks++; if (we_times.size() != nw)  begin n_fail++; $display("FAIL lenerr_no_write got %0d writes expected 0", we_times.size() - nw); end
        n_checks++; if (bus.load_err !== 1'b1)  begin n_fail++; $display("FAIL lenerr_err got %b expected 1", bus.load_err); end
        n_checks++; if (bus.cpu_hold !== 1'b1)  begin n_fail++; $display("FAIL lenerr_hold got %b expected 1", bus.cpu_hold); end
        n_checks++; if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL lenerr_done got %b expected 0", bus.load_done); end
        img = '{32'hDEAD_BEEF};
        send_frame(16'd1, 1, -1);
        finish_frame();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.load_err !== 1'b0)  begin n_fail++; $display("FAIL recover_err got %b expected 0", bus.load_err); end
        n_checks++; if (bus.cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL recover_hold got %b expected 0", bus.cpu_hold); end
        n_checks++; if (exp_q.size() != 0)      begin n_fail++; $display("FAIL recover_writes got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int nw;
        nw  = we_times.size();
        img = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
        send_frame(16'd3, 3, 6);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++; if (we_times.size() != nw + 1) begin n_fail++; $display("FAIL midreset_writes got %0d expected 1", we_times.size() - nw); end
        n_checks++; if (bus.cpu_hold !== 1'b0)     begin n_fail++; $display("FAIL midreset_hold got %b expected 0", bus.cpu_hold); end
        n_checks++; if (exp_q.size() != 0)         begin n_fail++; $display("FAIL midreset_pending got %0d expected 0", exp_q.size()); end
        img = '{32'h0BAD_F00D, 32'hCAFE_0001};
        send_frame(16'd2, 2, -1);
        finish_frame();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL reload_done got %b expected 1", bus.load_done); end
        n_checks++; if (exp_q.size() != 0)      begin n_fail++; $display("FAIL reload_writes got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        // SYNC-valued bytes inside data must be stored, not restart the frame.
        img = '{32'hA5A5_A5A5, 32'h0102_A503, 32'hFFFF_FFFF, 32'h5AA5_0000};
        we_times.delete();
        send_frame(16'd4, 0, -1);
        finish_frame();
        repeat (2) @(negedge clk);
        n_checks++;
        if (we_times.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_write_count got %0d expected 4", we_times.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (we_times[k] - we_times[k-1] != 5) begin
                    n_fail++;
                    $display("FAIL b2b_spacing idx=%0d got %0d clks expected 5", k, we_times[k] - we_times[k-1]);
                end
            end
        end
        n_checks++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b expected 1", bus.load_done); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        // Data bytes 37 DF EE FF XOR to F9; the computed value is what the loader must accept.
        img = '{32'hFFEE_DF37};
        send_frame(16'd1, 0, -1);
        send_byte(last_xor, 0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL chk_good_done got %b expected 1", bus.load_done); end
        n_checks++; if (bus.load_err !== 1'b0)  begin n_fail++; $display("FAIL chk_good_err got %b expected 0", bus.load_err); end
        send_frame(16'd1, 0, -1);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.load_err !== 1'b1)  begin n_fail++; $display("FAIL chk_bad_err got %b expected 1", bus.load_err); end
        n_checks++; if (bus.cpu_hold !== 1'b1)  begin n_fail++; $display("FAIL chk_bad_hold got %b expected 1", bus.cpu_hold); end
        n_checks++; if (exp_q.size() != 0)      begin n_fail++; $display("FAIL chk_bad_write got %0d pending expected 0", exp_q.size()); end
    endtask
`endif

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_basic();
        test_sync_skip();
        test_len_err();
        test_reset_mid();
        test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
